// File: rtl/video_stream_chk.sv
// Video stream geometry checker: tags beats with x/y, measures
// line width and frame height, tracks lock and error statistics.
module video_stream_chk #(
  parameter logic [11:0] H_ActivePix   = 12'd640,
  parameter logic [11:0] V_ActivePix   = 12'd480,
  parameter logic [2:0]  PixelPerClock = 3'd1,
  parameter logic        VS_POL        = 1'b1,
  parameter logic [3:0]  LOCK_FRAMES   = 4'd2,
  parameter int          PW            = 14,
  parameter int          EW            = 8
) (
  input  logic          in_pclk,
  input  logic          in_rstn,
  input  logic          in_vs,
  input  logic          in_hs,
  input  logic          in_de,
  input  logic          in_clr_err,
  output logic [PW-1:0] out_x,
  output logic [11:0]   out_y,
  output logic          out_valid,
  output logic          out_de,
  output logic          out_hs,
  output logic          out_vs,
  output logic          out_sof,
  output logic          out_eol,
  output logic [PW-1:0] out_width,
  output logic [11:0]   out_height,
  output logic          out_line_err,
  output logic          out_frame_err,
  output logic          out_err_sticky,
  output logic [EW-1:0] out_err_cnt,
  output logic          out_locked
);

  localparam logic [PW-1:0] PPC  = PW'(PixelPerClock);
  localparam logic [PW-1:0] HEXP = PW'(H_ActivePix);

  logic          de_s1_q, hs_s1_q, vs_s1_q, sof_s1_q;
  logic [PW-1:0] x_s1_q;
  logic [11:0]   y_s1_q;
  logic          de_q, hs_q, vs_q, sof_q, eol_q;
  logic [PW-1:0] x_q;
  logic [11:0]   y_q;

  logic [PW-1:0] x_cnt_q, beats_q, width_q;
  logic [11:0]   line_q, height_q;
  logic          vs_act_q, first_q, sof_pend_q, bad_q;
  logic          line_err_q, frame_err_q, sticky_q, locked_q;
  logic [3:0]    good_q;
  logic [EW-1:0] cnt_q;

  logic          vs_act, vs_edge, de_fall;
  logic [PW:0]   x_sum;
  logic [PW-1:0] x_d, beats_d, width_d;
  logic [11:0]   line_inc, line_d, line_end_cnt;
  logic          line_err_d, frame_err_d, good_frame, err_any;
  logic [3:0]    good_inc;
  logic [EW:0]   cnt_sum;
  logic [EW-1:0] cnt_d;

  // Edge detection, saturating counters and error decisions
  always_comb begin
    vs_act       = (in_vs == VS_POL);
    vs_edge      = vs_act & ~vs_act_q;
    de_fall      = de_s1_q & ~in_de;
    x_sum        = {1'b0, x_cnt_q} + {1'b0, PPC};
    x_d          = x_sum[PW] ? '1 : x_sum[PW-1:0];
    beats_d      = (beats_q == '1) ? beats_q : beats_q + PW'(1);
    width_d      = beats_q * PPC;
    line_inc     = (line_q == 12'hFFF) ? line_q : line_q + 12'd1;
    line_end_cnt = de_fall ? line_inc : line_q;
    line_d       = vs_edge ? 12'd0 : line_end_cnt;
    line_err_d   = de_fall & (width_d != HEXP);
    frame_err_d  = vs_edge & ~first_q & (line_end_cnt != V_ActivePix);
    err_any      = line_err_d | frame_err_d;
    good_frame   = vs_edge & ~first_q & ~err_any & ~bad_q;
    good_inc     = good_q + 4'd1;
    cnt_sum      = {1'b0, cnt_q} + (EW+1)'(line_err_d)
                 + (EW+1)'(frame_err_d);
    cnt_d        = cnt_sum[EW] ? '1 : cnt_sum[EW-1:0];
  end

  // Two-stage pipeline carrying sync, enable and beat tags
  always_ff @(posedge in_pclk) begin
    if (!in_rstn) begin
      de_s1_q  <= 1'b0;
      hs_s1_q  <= 1'b0;
      vs_s1_q  <= 1'b0;
      sof_s1_q <= 1'b0;
      x_s1_q   <= '0;
      y_s1_q   <= '0;
      de_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      de_s1_q  <= in_de;
      hs_s1_q  <= in_hs;
      vs_s1_q  <= in_vs;
      sof_s1_q <= in_de & (sof_pend_q | vs_edge);
      x_s1_q   <= in_de ? x_cnt_q : '0;
      y_s1_q   <= vs_edge ? 12'd0 : line_q;
      de_q     <= de_s1_q;
      hs_q     <= hs_s1_q;
      vs_q     <= vs_s1_q;
      sof_q    <= sof_s1_q;
      eol_q    <= de_fall;
      x_q      <= x_s1_q;
      y_q      <= y_s1_q;
    end
  end

  // Line/frame measurement and geometry error pulses
  always_ff @(posedge in_pclk) begin
    if (!in_rstn) begin
      x_cnt_q     <= '0;
      beats_q     <= '0;
      width_q     <= '0;
      line_q      <= '0;
      height_q    <= '0;
      vs_act_q    <= 1'b0;
      first_q     <= 1'b1;
      sof_pend_q  <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      x_cnt_q     <= in_de ? x_d : '0;
      beats_q     <= in_de ? beats_d : '0;
      vs_act_q    <= vs_act;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
      line_q      <= line_d;
      sof_pend_q  <= ~in_de & (sof_pend_q | vs_edge);
      if (de_fall)
        width_q <= width_d;
      if (vs_edge) begin
        height_q <= line_end_cnt;
        first_q  <= 1'b0;
      end
    end
  end

  // Lock tracking and sticky/saturating error statistics
  always_ff @(posedge in_pclk) begin
    if (!in_rstn) begin
      bad_q    <= 1'b0;
      good_q   <= '0;
      locked_q <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (vs_edge)
        bad_q <= 1'b0;
      else if (line_err_d)
        bad_q <= 1'b1;
      if (err_any) begin
        good_q   <= '0;
        locked_q <= 1'b0;
      end else if (good_frame && good_q < LOCK_FRAMES) begin
        good_q   <= good_inc;
        locked_q <= (good_inc >= LOCK_FRAMES);
      end
      if (in_clr_err) begin
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sticky_q <= sticky_q | err_any;
        cnt_q    <= cnt_d;
      end
    end
  end

  assign out_x          = x_q;
  assign out_y          = y_q;
  assign out_valid      = de_q;
  assign out_de         = de_q;
  assign out_hs         = hs_q;
  assign out_vs         = vs_q;
  assign out_sof        = sof_q;
  assign out_eol        = eol_q;
  assign out_width      = width_q;
  assign out_height     = height_q;
  assign out_line_err   = line_err_q;
  assign out_frame_err  = frame_err_q;
  assign out_err_sticky = sticky_q;
  assign out_err_cnt    = cnt_q;
  assign out_locked     = locked_q;

endmodule
